// File: rtl/axil_xbar_1xn.sv
// axil_xbar_1xn: 1-master to NUM_SLAVES-slave AXI4-Lite crossbar with base/mask decode and internal DECERR slave
module axil_xbar_1xn #(
   parameter int NUM_SLAVES = 3,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'ha0000048, 32'ha00003f8, 32'h80000000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hfffffff8, 32'hfffffff8, 32'hfff00000}
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            m_awaddr,
   input  logic                         m_awvalid,
   output logic                         m_awready,
   input  logic [DATA_W-1:0]            m_wdata,
   input  logic [DATA_W/8-1:0]          m_wstrb,
   input  logic                         m_wvalid,
   output logic                         m_wready,
   output logic [1:0]                   m_bresp,
   output logic                         m_bvalid,
   input  logic                         m_bready,
   input  logic [ADDR_W-1:0]            m_araddr,
   input  logic                         m_arvalid,
   output logic                         m_arready,
   output logic [DATA_W-1:0]            m_rdata,
   output logic [1:0]                   m_rresp,
   output logic                         m_rvalid,
   input  logic                         m_rready,
   output logic [NUM_SLAVES*ADDR_W-1:0] s_awaddr,
   output logic [NUM_SLAVES*DATA_W-1:0] s_wdata,
   output logic [NUM_SLAVES*DATA_W/8-1:0] s_wstrb,
   output logic [NUM_SLAVES*ADDR_W-1:0] s_araddr,
   output logic [NUM_SLAVES-1:0]        s_awvalid,
   output logic [NUM_SLAVES-1:0]        s_wvalid,
   output logic [NUM_SLAVES-1:0]        s_bready,
   output logic [NUM_SLAVES-1:0]        s_arvalid,
   output logic [NUM_SLAVES-1:0]        s_rready,
   input  logic [NUM_SLAVES-1:0]        s_awready,
   input  logic [NUM_SLAVES-1:0]        s_wready,
   input  logic [NUM_SLAVES-1:0]        s_bvalid,
   input  logic [NUM_SLAVES-1:0]        s_arready,
   input  logic [NUM_SLAVES-1:0]        s_rvalid,
   input  logic [NUM_SLAVES*2-1:0]      s_bresp,
   input  logic [NUM_SLAVES*2-1:0]      s_rresp,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);
   localparam int SW = $clog2(NUM_SLAVES + 1);
   localparam logic [SW-1:0] ERR = SW'(NUM_SLAVES);
   typedef enum logic [1:0] {WIDLE, WFWD, WRESP} wstate_t;
   typedef enum logic [1:0] {RIDLE, RFWD, RDATA} rstate_t;
   wstate_t wstate;
   rstate_t rstate;
   logic [SW-1:0] wsel, rsel;
   logic aw_done, w_done, aw_hs, w_hs;
   logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
   logic [1:0] b_resp, r_resp;
   logic [DATA_W-1:0] r_data;

   // Lowest index wins on overlap; no match routes to the internal error slave.
   function automatic logic [SW-1:0] decode(input logic [ADDR_W-1:0] a);
      logic [SW-1:0] s;
      s = ERR;
      for (int i = NUM_SLAVES - 1; i >= 0; i--)
         if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) s = SW'(i);
      return s;
   endfunction

   assign s_awaddr = {NUM_SLAVES{m_awaddr}};
   assign s_wdata  = {NUM_SLAVES{m_wdata}};
   assign s_wstrb  = {NUM_SLAVES{m_wstrb}};
   assign s_araddr = {NUM_SLAVES{m_araddr}};

   always_comb begin
      s_awvalid = '0;
      s_wvalid = '0;
      s_bready = '0;
      aw_rdy = wsel == ERR;
      w_rdy = wsel == ERR;
      b_vld = wsel == ERR;
      b_resp = wsel == ERR ? 2'b11 : 2'b00;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (wsel == SW'(i)) begin
            s_awvalid[i] = wstate == WFWD && m_awvalid && !aw_done;
            s_wvalid[i] = wstate == WFWD && m_wvalid && !w_done;
            s_bready[i] = wstate == WRESP && m_bready;
            aw_rdy = s_awready[i];
            w_rdy = s_wready[i];
            b_vld = s_bvalid[i];
            b_resp = s_bresp[i*2 +: 2];
         end
   end

   assign m_awready = (wstate == WFWD) && aw_rdy && !aw_done;
   assign m_wready  = (wstate == WFWD) && w_rdy && !w_done;
   assign m_bvalid  = (wstate == WRESP) && b_vld;
   assign m_bresp   = wstate == WRESP ? b_resp : 2'b00;
   assign aw_hs     = m_awvalid && m_awready;
   assign w_hs      = m_wvalid && m_wready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate <= WIDLE;
         wsel <= '0;
         aw_done <= 1'b0;
         w_done <= 1'b0;
      end else begin
         case (wstate)
            WIDLE: if (m_awvalid) begin
               wsel <= decode(m_awaddr);
               aw_done <= 1'b0;
               w_done <= 1'b0;
               wstate <= WFWD;
            end
            WFWD: begin
               aw_done <= aw_done | aw_hs;
               w_done <= w_done | w_hs;
               if ((aw_done || aw_hs) && (w_done || w_hs)) wstate <= WRESP;
            end
            WRESP: if (m_bvalid && m_bready) wstate <= WIDLE;
            default: wstate <= WIDLE;
         endcase
      end
   end

   always_comb begin
      s_arvalid = '0;
      s_rready = '0;
      ar_rdy = rsel == ERR;
      r_vld = rsel == ERR;
      r_resp = rsel == ERR ? 2'b11 : 2'b00;
      r_data = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (rsel == SW'(i)) begin
            s_arvalid[i] = rstate == RFWD && m_arvalid;
            s_rready[i] = rstate == RDATA && m_rready;
            ar_rdy = s_arready[i];
            r_vld = s_rvalid[i];
            r_resp = s_rresp[i*2 +: 2];
            r_data = s_rdata[i*DATA_W +: DATA_W];
         end
   end

   assign m_arready = (rstate == RFWD) && ar_rdy;
   assign m_rvalid  = (rstate == RDATA) && r_vld;
   assign m_rresp   = rstate == RDATA ? r_resp : 2'b00;
   assign m_rdata   = rstate == RDATA ? r_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rstate <= RIDLE;
         rsel <= '0;
      end else begin
         case (rstate)
            RIDLE: if (m_arvalid) begin
               rsel <= decode(m_araddr);
               rstate <= RFWD;
            end
            RFWD: if (m_arvalid && m_arready) rstate <= RDATA;
            RDATA: if (m_rvalid && m_rready) rstate <= RIDLE;
            default: rstate <= RIDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axil_xbar_1xn.sv
// tb_axil_xbar_1xn: directed stimulus with per-cycle transaction-level model check
module tb_axil_xbar_1xn;
   localparam int NS = 3;
   localparam logic [31:0] BASE [NS] = '{32'h80000000, 32'ha00003f8, 32'ha0000048};
   localparam logic [31:0] MASK [NS] = '{32'hfff00000, 32'hfffffff8, 32'hfffffff8};

   logic clk, rst;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0] m_wstrb;
   logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0] m_bresp, m_rresp;
   logic [NS*32-1:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [NS*4-1:0] s_wstrb;
   logic [NS-1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
   logic [NS-1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [NS*2-1:0] s_bresp, s_rresp;

   int tests = 0, errs = 0;
   int aw_delay [NS];
   int r_delay [NS];
   logic [31:0] r_val [NS];

   axil_xbar_1xn dut (
      .clk(clk), .rst(rst),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_araddr(s_araddr),
      .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_rready(s_rready),
      .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
      .s_arready(s_arready), .s_rvalid(s_rvalid),
      .s_bresp(s_bresp), .s_rresp(s_rresp), .s_rdata(s_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Slave models: configurable AW wait and read latency, zero-wait elsewhere.
   for (genvar g = 0; g < NS; g++) begin : sl
      int aw_cnt, r_cnt;
      bit aw_got, w_got, bv, rp, rv;
      logic [31:0] w_last;
      logic aw_hs, w_hs, ar_hs;
      assign aw_hs = s_awvalid[g] & s_awready[g];
      assign w_hs = s_wvalid[g] & s_wready[g];
      assign ar_hs = s_arvalid[g] & s_arready[g];
      assign s_awready[g] = aw_cnt >= aw_delay[g];
      assign s_wready[g] = 1'b1;
      assign s_bvalid[g] = bv;
      assign s_bresp[2*g +: 2] = 2'b00;
      assign s_arready[g] = 1'b1;
      assign s_rvalid[g] = rv;
      assign s_rresp[2*g +: 2] = 2'b00;
      assign s_rdata[32*g +: 32] = rv ? r_val[g] : 32'h0;
      always @(posedge clk) begin
         if (rst) begin
            aw_cnt <= 0; r_cnt <= 0; aw_got <= 0; w_got <= 0; bv <= 0; rp <= 0; rv <= 0; w_last <= 0;
         end else begin
            if (aw_hs) begin aw_got <= 1; aw_cnt <= 0; end
            else if (s_awvalid[g]) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin w_got <= 1; w_last <= s_wdata[32*g +: 32]; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin bv <= 1; aw_got <= 0; w_got <= 0; end
            if (bv && s_bready[g]) bv <= 0;
            if (ar_hs) begin rp <= 1; r_cnt <= r_delay[g]; end
            else if (rp) begin
               if (r_cnt == 0) begin rv <= 1; rp <= 0; end
               else r_cnt <= r_cnt - 1;
            end
            if (rv && s_rready[g]) rv <= 0;
         end
      end
   end

   function automatic int ref_decode(input logic [31:0] a);
      for (int k = 0; k < NS; k++) if ((a & MASK[k]) == BASE[k]) return k;
      return NS;
   endfunction

   function automatic bit pick(input logic [NS-1:0] v, input int i);
      for (int k = 0; k < NS; k++) if (k == i) return v[k];
      return 1'b1;
   endfunction

   function automatic logic [1:0] pick_resp(input logic [NS*2-1:0] v, input int i);
      for (int k = 0; k < NS; k++) if (k == i) return v[2*k +: 2];
      return 2'b11;
   endfunction

   function automatic logic [31:0] pick_data(input logic [NS*32-1:0] v, input int i);
      for (int k = 0; k < NS; k++) if (k == i) return v[32*k +: 32];
      return 32'h0;
   endfunction

   // Model: per channel a phase (0 idle, 1 address/data forwarding, 2 response) and target index.
   int wph = 0, rph = 0, wt = 0, rt = 0;
   bit awa = 0, wa = 0;
   bit e_awready, e_wready, e_bvalid, e_arready, e_rvalid;
   logic [NS-1:0] ea, ew, eb, ear, er;

   always @(negedge clk) begin
      for (int k = 0; k < NS; k++) begin
         ea[k] = wph == 1 && wt == k && m_awvalid && !awa;
         ew[k] = wph == 1 && wt == k && m_wvalid && !wa;
         eb[k] = wph == 2 && wt == k && m_bready;
         ear[k] = rph == 1 && rt == k && m_arvalid;
         er[k] = rph == 2 && rt == k && m_rready;
      end
      e_awready = wph == 1 && !awa && pick(s_awready, wt);
      e_wready = wph == 1 && !wa && pick(s_wready, wt);
      e_bvalid = wph == 2 && pick(s_bvalid, wt);
      e_arready = rph == 1 && pick(s_arready, rt);
      e_rvalid = rph == 2 && pick(s_rvalid, rt);
      chk("s_awvalid", s_awvalid, ea);
      chk("s_wvalid", s_wvalid, ew);
      chk("s_bready", s_bready, eb);
      chk("s_arvalid", s_arvalid, ear);
      chk("s_rready", s_rready, er);
      chk("m_awready", m_awready, e_awready);
      chk("m_wready", m_wready, e_wready);
      chk("m_bvalid", m_bvalid, e_bvalid);
      chk("m_arready", m_arready, e_arready);
      chk("m_rvalid", m_rvalid, e_rvalid);
      chk("s_awaddr_bcast", s_awaddr, {NS{m_awaddr}});
      chk("s_wdata_bcast", s_wdata, {NS{m_wdata}});
      chk("s_araddr_bcast", s_araddr, {NS{m_araddr}});
      if (e_bvalid) chk("m_bresp", m_bresp, pick_resp(s_bresp, wt));
      if (e_rvalid) begin
         chk("m_rresp", m_rresp, pick_resp(s_rresp, rt));
         chk("m_rdata", m_rdata, pick_data(s_rdata, rt));
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         wph <= 0; rph <= 0; wt <= 0; rt <= 0; awa <= 0; wa <= 0;
      end else begin
         if (wph == 0 && m_awvalid) begin wt <= ref_decode(m_awaddr); awa <= 0; wa <= 0; wph <= 1; end
         else if (wph == 1) begin
            awa <= awa || (m_awvalid && e_awready);
            wa <= wa || (m_wvalid && e_wready);
            if ((awa || (m_awvalid && e_awready)) && (wa || (m_wvalid && e_wready))) wph <= 2;
         end else if (wph == 2 && e_bvalid && m_bready) wph <= 0;
         if (rph == 0 && m_arvalid) begin rt <= ref_decode(m_araddr); rph <= 1; end
         else if (rph == 1 && m_arvalid && e_arready) rph <= 2;
         else if (rph == 2 && e_rvalid && m_rready) rph <= 0;
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int pre_w, input int bhold,
                           output logic [1:0] resp, output int lat);
      bit awf, wf, bf, done;
      int held;
      done = 0; held = 0; lat = -1; resp = 2'bxx;
      m_awaddr = a; m_wdata = d; m_wstrb = 4'hf; m_bready = bhold == 0;
      if (pre_w > 0) begin
         m_wvalid = 1;
         repeat (pre_w) begin
            @(negedge clk);
            chk("wready_before_aw", m_wready, 0);
            @(posedge clk); #1;
         end
      end
      m_awvalid = 1; m_wvalid = 1;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         awf = m_awvalid & m_awready;
         wf = m_wvalid & m_wready;
         bf = m_bvalid & m_bready;
         if (lat >= 0) begin
            chk("bvalid_held", m_bvalid, 1);
            chk("awready_in_resp", m_awready, 0);
         end
         if (m_bvalid && lat < 0) lat = n;
         if (bf) resp = m_bresp;
         @(posedge clk); #1;
         if (bf) begin
            m_awvalid = 0; m_wvalid = 0; m_bready = 1; done = 1;
         end else begin
            if (awf) m_awvalid = 0;
            if (wf) m_wvalid = 0;
            if (lat >= 0) begin
               held++;
               if (held >= bhold) m_bready = 1;
               if (bhold > 0) begin m_awvalid = 1; m_awaddr = 32'h80000100; end
            end
         end
      end
      if (!done) begin
         tests++; errs++;
         $display("FAIL write_timeout: no B response for %0h", a);
         m_awvalid = 0; m_wvalid = 0;
      end
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ar_seen);
      bit arf, rf, done;
      done = 0; ar_seen = 0; d = 'x; resp = 2'bxx;
      m_araddr = a; m_arvalid = 1; m_rready = 1;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         arf = m_arvalid & m_arready;
         rf = m_rvalid & m_rready;
         if (arf) ar_seen = 1;
         if (rf) begin d = m_rdata; resp = m_rresp; end
         @(posedge clk); #1;
         if (arf) m_arvalid = 0;
         if (rf) done = 1;
      end
      if (!done) begin
         tests++; errs++;
         $display("FAIL read_timeout: no R response for %0h", a);
         m_arvalid = 0;
      end
   endtask

   logic [1:0] bresp, rresp;
   logic [31:0] rd;
   int lat;
   bit ars, ok;

   initial begin
      rst = 1;
      m_awaddr = 0; m_awvalid = 0; m_wdata = 0; m_wstrb = 0; m_wvalid = 0; m_bready = 1;
      m_araddr = 0; m_arvalid = 0; m_rready = 1;
      for (int k = 0; k < NS; k++) begin aw_delay[k] = 0; r_delay[k] = 0; r_val[k] = 32'h100 + k; end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_handshakes", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                               s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
      chk("reset_resp_data", {m_bresp, m_rresp, m_rdata}, 0);
      chk("dec_sram", ref_decode(32'h80000010), 0);
      chk("dec_uart", ref_decode(32'ha00003fc), 1);
      chk("dec_clint", ref_decode(32'ha0000048), 2);
      chk("dec_unmapped", ref_decode(32'h90000000), 3);
      @(posedge clk); #1;

      do_write(32'h80000010, 32'hdeadbeef, 0, 0, bresp, lat);
      chk("w0_lat", lat, 2);
      chk("w0_bresp", bresp, 2'b00);
      chk("w0_data", sl[0].w_last, 32'hdeadbeef);

      r_val[1] = 32'h41;
      fork
         do_write(32'ha0000048, 32'hcafe0001, 0, 0, bresp, lat);
         do_read(32'ha00003f8, rd, rresp, ars);
      join
      chk("conc_rdata", rd, 32'h41);
      chk("conc_rresp", rresp, 2'b00);
      chk("conc_bresp", bresp, 2'b00);
      chk("conc_wdata", sl[2].w_last, 32'hcafe0001);

      do_read(32'h90000000, rd, rresp, ars);
      chk("err_rd_arready", ars, 1);
      chk("err_rdata", rd, 32'h0);
      chk("err_rresp", rresp, 2'b11);

      do_write(32'h12345678, 32'h1, 0, 0, bresp, lat);
      chk("err_bresp", bresp, 2'b11);
      chk("err_wlat", lat, 2);

      aw_delay[0] = 3;
      do_write(32'h80000004, 32'h0badf00d, 2, 0, bresp, lat);
      chk("wfirst_bresp", bresp, 2'b00);
      chk("wfirst_lat", lat, 5);
      chk("wfirst_data", sl[0].w_last, 32'h0badf00d);
      aw_delay[0] = 0;

      do_write(32'h80000008, 32'h5, 0, 4, bresp, lat);
      chk("bhold_bresp", bresp, 2'b00);
      chk("bhold_lat", lat, 2);

      r_delay[0] = 20; r_val[0] = 32'h12345678;
      m_araddr = 32'h80000020; m_arvalid = 1; m_rready = 1; ok = 0;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge clk);
         ok = m_arready;
         @(posedge clk); #1;
      end
      chk("rst_ar_accepted", ok, 1);
      m_arvalid = 0; rst = 1;
      @(negedge clk);
      chk("rvalid_before_rst", m_rvalid, 0);
      @(posedge clk); #1;
      rst = 0; r_delay[0] = 0;
      @(negedge clk);
      chk("post_rst_handshakes", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                                  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
      @(posedge clk); #1;
      do_read(32'h80000020, rd, rresp, ars);
      chk("post_rst_rdata", rd, 32'h12345678);
      chk("post_rst_rresp", rresp, 2'b00);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
